// File: rtl/itlb_walker_pkg.sv
// Shared PTE layout, walk levels and walker state encoding for the ITLB page-table walker.
// Pure definitions: no latency, no flow control.
package itlb_walker_pkg;

  localparam int NPHYS_DEF = 44;
  localparam int VA_SZ_DEF = 48;

  localparam int PTE_V       = 0;
  localparam int PTE_R       = 1;
  localparam int PTE_W       = 2;
  localparam int PTE_X       = 3;
  localparam int PTE_U       = 4;
  localparam int PTE_G       = 5;
  localparam int PTE_A       = 6;
  localparam int PTE_D       = 7;
  localparam int PTE_PPN_LSB = 10;

  localparam logic [1:0] LVL_4K   = 2'd0;
  localparam logic [1:0] LVL_2M   = 2'd1;
  localparam logic [1:0] LVL_1G   = 2'd2;
  localparam logic [1:0] LVL_512G = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DRAIN,
    ST_FILL,
    ST_FAULT
  } state_e;

endpackage

// File: rtl/itlb_pte_check.sv
// Combinational PTE classifier: leaf/pointer, page-fault conditions, superpage alignment.
// Zero latency; no flow control.
module itlb_pte_check
  import itlb_walker_pkg::*;
(
  input  logic [63:0] pte,
  input  logic [1:0]  lvl,
  output logic        leaf,
  output logic        pointer,
  output logic        page_fault,
  output logic        misaligned
);

  logic invalid;
  logic unused_bits;

  // Bits not needed for classification (upper PPN, D, RSW, U, G) are consumed by the walker.
  assign unused_bits = ^{pte[53:37], pte[9:7], pte[5:4]};

  always_comb begin
    invalid    = !pte[PTE_V] || (!pte[PTE_R] && pte[PTE_W]) || (pte[63:54] != 10'd0);
    pointer    = !invalid && !pte[PTE_R] && !pte[PTE_X];
    leaf       = !invalid && (pte[PTE_R] || pte[PTE_X]);
    misaligned = 1'b0;
    case (lvl)
      LVL_2M:   misaligned = leaf && (pte[PTE_PPN_LSB+8:PTE_PPN_LSB] != '0);
      LVL_1G:   misaligned = leaf && (pte[PTE_PPN_LSB+17:PTE_PPN_LSB] != '0);
      LVL_512G: misaligned = leaf && (pte[PTE_PPN_LSB+26:PTE_PPN_LSB] != '0);
      default:  misaligned = 1'b0;
    endcase
    // Hardware never sets A, so an instruction leaf without A is unusable.
    page_fault = invalid || (pointer && (lvl == LVL_4K)) ||
                 (leaf && (!pte[PTE_X] || !pte[PTE_A]));
  end

endmodule

// File: rtl/itlb_walker.sv
// Sv39/Sv48 instruction-TLB miss walker: one miss at a time, fills the ITLB or reports a fault.
// Latency 1 + levels*(mem latency + 1) + 1; miss_ready only in IDLE, mem_req held until mem_ack.
module itlb_walker
  import itlb_walker_pkg::*;
#(
  parameter int NPHYS = NPHYS_DEF,
  parameter int VA_SZ = VA_SZ_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                satp_mode,
  input  logic [NPHYS-13:0]   satp_ppn,
  input  logic                miss_valid,
  output logic                miss_ready,
  input  logic [VA_SZ-13:0]   miss_vaddr,
  input  logic [15:0]         miss_asid,
  input  logic                flush,
  output logic                mem_req,
  input  logic                mem_ack,
  output logic [NPHYS-1:0]    mem_addr,
  input  logic                mem_rvalid,
  input  logic [63:0]         mem_rdata,
  input  logic                mem_rerr,
  output logic                wr_entry,
  output logic [VA_SZ-13:0]   wr_vaddr,
  output logic [15:0]         wr_asid,
  output logic [NPHYS-13:0]   wr_paddr,
  output logic [3:0]          wr_gaux,
  output logic                wr_2mB,
  output logic                wr_4mB,
  output logic                wr_1gB,
  output logic                wr_512gB,
  output logic                done,
  output logic                fault_page,
  output logic                fault_access
);

  localparam int VPN_W = VA_SZ - 12;
  localparam int PPN_W = NPHYS - 12;

  state_e             state_q, state_d;
  logic [1:0]         lvl_q, lvl_d;
  logic [PPN_W-1:0]   ppn_q, ppn_d;
  logic [VPN_W-1:0]   vpn_q, vpn_d;
  logic [15:0]        asid_q, asid_d;
  logic               miss_ready_q, miss_ready_d;
  logic               mem_req_q, mem_req_d;
  logic [NPHYS-1:0]   mem_addr_q, mem_addr_d;
  logic               done_q, done_d;
  logic               fill_q, fill_d;
  logic               fault_page_q, fault_page_d;
  logic               fault_access_q, fault_access_d;
  logic [VPN_W-1:0]   wr_vaddr_q, wr_vaddr_d;
  logic [15:0]        wr_asid_q, wr_asid_d;
  logic [PPN_W-1:0]   wr_paddr_q, wr_paddr_d;
  logic [3:0]         wr_gaux_q, wr_gaux_d;
  logic [2:0]         wr_size_q, wr_size_d;

  logic pte_leaf, pte_ptr, pte_fault, pte_misaligned;
  logic sv39_canonical;

  itlb_pte_check u_pte_check (
    .pte        (mem_rdata),
    .lvl        (lvl_q),
    .leaf       (pte_leaf),
    .pointer    (pte_ptr),
    .page_fault (pte_fault),
    .misaligned (pte_misaligned)
  );

  function automatic logic [8:0] vpn_idx(input logic [VPN_W-1:0] v, input logic [1:0] l);
    case (l)
      LVL_4K:  return v[8:0];
      LVL_2M:  return v[17:9];
      LVL_1G:  return v[26:18];
      default: return v[35:27];
    endcase
  endfunction

  assign sv39_canonical = (miss_vaddr[VPN_W-1:27] == {(VPN_W-27){miss_vaddr[26]}});

  always_comb begin
    state_d        = state_q;
    lvl_d          = lvl_q;
    ppn_d          = ppn_q;
    vpn_d          = vpn_q;
    asid_d         = asid_q;
    wr_vaddr_d     = wr_vaddr_q;
    wr_asid_d      = wr_asid_q;
    wr_paddr_d     = wr_paddr_q;
    wr_gaux_d      = wr_gaux_q;
    wr_size_d      = wr_size_q;
    fault_page_d   = 1'b0;
    fault_access_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (miss_valid) begin
          vpn_d  = miss_vaddr;
          asid_d = miss_asid;
          ppn_d  = satp_ppn;
          lvl_d  = satp_mode ? LVL_512G : LVL_1G;
          if (!satp_mode && !sv39_canonical) begin
            state_d      = ST_FAULT;
            fault_page_d = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // A flush racing the ack still leaves a response in flight to be drained.
        if (mem_ack)    state_d = flush ? ST_DRAIN : ST_WAIT;
        else if (flush) state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (flush) begin
          state_d = mem_rvalid ? ST_IDLE : ST_DRAIN;
        end else if (mem_rvalid) begin
          if (mem_rerr) begin
            state_d        = ST_FAULT;
            fault_access_d = 1'b1;
          end else if (pte_fault || pte_misaligned) begin
            state_d      = ST_FAULT;
            fault_page_d = 1'b1;
          end else if (pte_ptr) begin
            ppn_d   = mem_rdata[NPHYS-3:PTE_PPN_LSB];
            lvl_d   = lvl_q - 2'd1;
            state_d = ST_REQ;
          end else if (pte_leaf) begin
            state_d    = ST_FILL;
            wr_vaddr_d = vpn_q;
            wr_asid_d  = asid_q;
            wr_paddr_d = mem_rdata[NPHYS-3:PTE_PPN_LSB];
            wr_gaux_d  = {mem_rdata[PTE_G], mem_rdata[PTE_U], mem_rdata[PTE_X], mem_rdata[PTE_A]};
            wr_size_d  = {lvl_q == LVL_512G, lvl_q == LVL_1G, lvl_q == LVL_2M};
          end else begin
            state_d      = ST_FAULT;
            fault_page_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (mem_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    miss_ready_d = (state_d == ST_IDLE);
    mem_req_d    = (state_d == ST_REQ);
    mem_addr_d   = mem_req_d ? {ppn_d, vpn_idx(vpn_d, lvl_d), 3'b000} : '0;
    done_d       = (state_d == ST_FILL) || (state_d == ST_FAULT);
    fill_d       = (state_d == ST_FILL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      lvl_q          <= '0;
      ppn_q          <= '0;
      vpn_q          <= '0;
      asid_q         <= '0;
      miss_ready_q   <= 1'b1;
      mem_req_q      <= 1'b0;
      mem_addr_q     <= '0;
      done_q         <= 1'b0;
      fill_q         <= 1'b0;
      fault_page_q   <= 1'b0;
      fault_access_q <= 1'b0;
      wr_vaddr_q     <= '0;
      wr_asid_q      <= '0;
      wr_paddr_q     <= '0;
      wr_gaux_q      <= '0;
      wr_size_q      <= '0;
    end else begin
      state_q        <= state_d;
      lvl_q          <= lvl_d;
      ppn_q          <= ppn_d;
      vpn_q          <= vpn_d;
      asid_q         <= asid_d;
      miss_ready_q   <= miss_ready_d;
      mem_req_q      <= mem_req_d;
      mem_addr_q     <= mem_addr_d;
      done_q         <= done_d;
      fill_q         <= fill_d;
      fault_page_q   <= fault_page_d;
      fault_access_q <= fault_access_d;
      wr_vaddr_q     <= wr_vaddr_d;
      wr_asid_q      <= wr_asid_d;
      wr_paddr_q     <= wr_paddr_d;
      wr_gaux_q      <= wr_gaux_d;
      wr_size_q      <= wr_size_d;
    end
  end

  assign miss_ready   = miss_ready_q;
  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  // A flush arriving in FILL/FAULT cancels the result outright.
  assign wr_entry     = fill_q & ~flush;
  assign done         = done_q & ~flush;
  assign fault_page   = fault_page_q & ~flush;
  assign fault_access = fault_access_q & ~flush;
  assign wr_vaddr     = wr_vaddr_q;
  assign wr_asid      = wr_asid_q;
  assign wr_paddr     = wr_paddr_q;
  assign wr_gaux      = wr_gaux_q;
  assign wr_512gB     = wr_size_q[2];
  assign wr_1gB       = wr_size_q[1];
  assign wr_2mB       = wr_size_q[0];
  assign wr_4mB       = 1'b0;

endmodule

// File: tb/tb_itlb_walker.sv
// Directed bench for itlb_walker: Sv39/Sv48 walks, superpages, faults, flushes, async reset.
module tb_itlb_walker;

  logic        clk = 1'b0;
  logic        reset;
  logic        satp_mode;
  logic [31:0] satp_ppn;
  logic        miss_valid;
  logic        miss_ready;
  logic [35:0] miss_vaddr;
  logic [15:0] miss_asid;
  logic        flush;
  logic        mem_req;
  logic        mem_ack;
  logic [43:0] mem_addr;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        mem_rerr;
  logic        wr_entry;
  logic [35:0] wr_vaddr;
  logic [15:0] wr_asid;
  logic [31:0] wr_paddr;
  logic [3:0]  wr_gaux;
  logic        wr_2mB, wr_4mB, wr_1gB, wr_512gB;
  logic        done, fault_page, fault_access;

  int tests = 0;
  int fails = 0;
  int n_wr = 0, n_done = 0, n_rd = 0;
  int s_wr, s_done, s_rd;

  always #5 clk = ~clk;

  itlb_walker dut (
    .clk(clk), .reset(reset), .satp_mode(satp_mode), .satp_ppn(satp_ppn),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_vaddr(miss_vaddr),
    .miss_asid(miss_asid), .flush(flush), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_rerr(mem_rerr), .wr_entry(wr_entry), .wr_vaddr(wr_vaddr), .wr_asid(wr_asid),
    .wr_paddr(wr_paddr), .wr_gaux(wr_gaux), .wr_2mB(wr_2mB), .wr_4mB(wr_4mB),
    .wr_1gB(wr_1gB), .wr_512gB(wr_512gB), .done(done), .fault_page(fault_page),
    .fault_access(fault_access)
  );

  always @(posedge clk) begin
    if (wr_entry) n_wr++;
    if (done) n_done++;
    if (mem_req && mem_ack) n_rd++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_miss(input logic mode, input logic [35:0] vpn, input logic [15:0] asid);
    chk("accept_ready", miss_ready, 1);
    satp_mode  = mode;
    miss_vaddr = vpn;
    miss_asid  = asid;
    miss_valid = 1'b1;
    @(negedge clk);
    miss_valid = 1'b0;
  endtask

  task automatic wait_req(input string tag, input logic [43:0] addr);
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, mem_req, 1);
    chk({tag, "_addr"}, mem_addr, addr);
  endtask

  task automatic serve(input string tag, input logic [43:0] addr, input logic [63:0] pte,
                       input logic rerr);
    wait_req(tag, addr);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = pte;
    mem_rerr   = rerr;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    mem_rerr   = 1'b0;
  endtask

  initial begin
    reset = 1'b0; satp_mode = 1'b0; satp_ppn = 32'h80000; miss_valid = 1'b0;
    miss_vaddr = '0; miss_asid = '0; flush = 1'b0; mem_ack = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0; mem_rerr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_miss_ready", miss_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_entry", wr_entry, 0);
    chk("rst_wr_paddr", wr_paddr, 0);
    reset = 1'b1;
    @(negedge clk);

    // Sv39 4KB walk
    send_miss(1'b0, 36'h40203, 16'hABCD);
    serve("4k_l2", 44'h80000008, 64'h20000401, 1'b0);
    serve("4k_l1", 44'h80001008, 64'h20000801, 1'b0);
    serve("4k_l0", 44'h80002018, 64'h048D144B, 1'b0);
    chk("4k_wr_entry", wr_entry, 1);
    chk("4k_done", done, 1);
    chk("4k_fault", {fault_page, fault_access}, 0);
    chk("4k_paddr", wr_paddr, 32'h12345);
    chk("4k_gaux", wr_gaux, 4'b0011);
    chk("4k_size", {wr_512gB, wr_1gB, wr_4mB, wr_2mB}, 0);
    chk("4k_vaddr", wr_vaddr, 36'h40203);
    chk("4k_asid", wr_asid, 16'hABCD);
    @(negedge clk);
    chk("4k_wr_entry_off", wr_entry, 0);
    chk("4k_done_off", done, 0);
    chk("4k_ready_back", miss_ready, 1);
    chk("4k_paddr_stable", wr_paddr, 32'h12345);

    // 2MB leaf at level 1, then a misaligned one
    send_miss(1'b0, 36'h40203, 16'h0001);
    serve("2m_l2", 44'h80000008, 64'h20000401, 1'b0);
    serve("2m_l1", 44'h80001008, 64'h2008004B, 1'b0);
    chk("2m_wr_entry", wr_entry, 1);
    chk("2m_size", {wr_512gB, wr_1gB, wr_4mB, wr_2mB}, 4'b0001);
    chk("2m_paddr", wr_paddr, 32'h80200);
    @(negedge clk);
    s_wr = n_wr;
    send_miss(1'b0, 36'h40203, 16'h0001);
    serve("2mbad_l2", 44'h80000008, 64'h20000401, 1'b0);
    serve("2mbad_l1", 44'h80001008, 64'h2008044B, 1'b0);
    chk("2mbad_done", done, 1);
    chk("2mbad_fault", {fault_page, fault_access}, 2'b10);
    chk("2mbad_wr_entry", wr_entry, 0);
    @(negedge clk);
    chk("2mbad_no_fill", n_wr, s_wr);

    // Invalid first PTE: a single read then a page fault
    s_rd = n_rd;
    send_miss(1'b0, 36'h40203, 16'h0002);
    serve("v0_l2", 44'h80000008, 64'h0, 1'b0);
    chk("v0_done", done, 1);
    chk("v0_fault", {fault_page, fault_access}, 2'b10);
    @(negedge clk);
    chk("v0_reads", n_rd - s_rd, 1);
    chk("v0_mem_req", mem_req, 0);

    // Bus error on the second read
    send_miss(1'b0, 36'h40203, 16'h0003);
    serve("err_l2", 44'h80000008, 64'h20000401, 1'b0);
    serve("err_l1", 44'h80001008, 64'h2008004B, 1'b1);
    chk("err_done", done, 1);
    chk("err_fault", {fault_page, fault_access}, 2'b01);
    chk("err_wr_entry", wr_entry, 0);
    @(negedge clk);
    chk("err_ready_back", miss_ready, 1);

    // Flush while waiting on the second read: response drained silently
    s_wr = n_wr; s_done = n_done;
    send_miss(1'b0, 36'h40203, 16'h0004);
    serve("fw_l2", 44'h80000008, 64'h20000401, 1'b0);
    wait_req("fw_l1", 44'h80001008);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    flush   = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fw_drain_ready", miss_ready, 0);
    chk("fw_drain_req", mem_req, 0);
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h2008004B;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    chk("fw_ready_back", miss_ready, 1);
    chk("fw_no_done", n_done, s_done);
    chk("fw_no_fill", n_wr, s_wr);
    send_miss(1'b0, 36'h40203, 16'h0055);
    serve("fw2_l2", 44'h80000008, 64'h20000401, 1'b0);
    serve("fw2_l1", 44'h80001008, 64'h20000801, 1'b0);
    serve("fw2_l0", 44'h80002018, 64'h048D144B, 1'b0);
    chk("fw2_wr_entry", wr_entry, 1);
    chk("fw2_asid", wr_asid, 16'h0055);
    @(negedge clk);

    // 1GB leaf with a flush landing on the FILL cycle
    s_wr = n_wr;
    send_miss(1'b0, 36'h40203, 16'h0006);
    serve("1g_l2", 44'h80000008, 64'h1000004B, 1'b0);
    chk("1g_size", {wr_512gB, wr_1gB, wr_4mB, wr_2mB}, 4'b0100);
    chk("1g_paddr", wr_paddr, 32'h40000);
    flush = 1'b1;
    #1;
    chk("1g_flush_wr_entry", wr_entry, 0);
    chk("1g_flush_done", done, 0);
    @(negedge clk);
    flush = 1'b0;
    chk("1g_ready_back", miss_ready, 1);
    chk("1g_no_fill", n_wr, s_wr);

    // Sv39 non-canonical address: immediate fault, no memory traffic
    s_rd = n_rd;
    send_miss(1'b0, 36'h4000000, 16'h0007);
    chk("sign_done", done, 1);
    chk("sign_fault", {fault_page, fault_access}, 2'b10);
    chk("sign_mem_req", mem_req, 0);
    @(negedge clk);
    chk("sign_reads", n_rd - s_rd, 0);

    // Sv48 start at level 3 (same VPN would be non-canonical under Sv39), flushed in REQ
    s_done = n_done;
    send_miss(1'b1, 36'h2C000000, 16'h0008);
    wait_req("sv48_l3", 44'h80000028);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("sv48_flush_req", mem_req, 0);
    chk("sv48_flush_ready", miss_ready, 1);
    chk("sv48_no_done", n_done, s_done);

    // Flush in IDLE is ignored and the same-cycle miss is taken
    flush = 1'b1;
    send_miss(1'b0, 36'h40203, 16'h0009);
    flush = 1'b0;
    wait_req("idleflush_l2", 44'h80000008);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;

    // Asynchronous reset in the middle of WAIT
    send_miss(1'b0, 36'h40203, 16'h000A);
    wait_req("arst_l2", 44'h80000008);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("arst_wait_ready", miss_ready, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_ready", miss_ready, 1);
    chk("arst_mem_req", mem_req, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("arst_after_ready", miss_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/itlb_walker.md
Name: itlb_walker

Overview:
- Hardware page-table walker that services instruction-TLB misses and writes the result into the ITLB fill port (wr_entry and related signals).
- Accepts one miss at a time from fetch, walks Sv39/Sv48 tables through a single 64-bit memory read port, then either fills the ITLB or reports a fetch page/access fault.
- Sits between fetch, the ITLB and the L2/memory arbiter.

Parameters:
- NPHYS, 44, physical address width.
- VA_SZ, 48, virtual address width (Sv48 max).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- satp_mode  in  1  0=Sv39 (start level 2), 1=Sv48 (start level 3)
- satp_ppn  in  NPHYS-12  root table PPN
- miss_valid  in  1  miss request
- miss_ready  out  1  walker idle; request accepted when miss_valid&&miss_ready
- miss_vaddr  in  VA_SZ-12  faulting VPN [VA_SZ-1:12]
- miss_asid  in  16  ASID
- flush  in  1  sfence/satp change; abort the walk
- mem_req  out  1  read request, held until mem_ack
- mem_ack  in  1  request accepted
- mem_addr  out  NPHYS  PTE byte address, 8-aligned
- mem_rvalid  in  1  read data valid
- mem_rdata  in  64  PTE
- mem_rerr  in  1  bus error on the read
- wr_entry  out  1  one-cycle ITLB fill strobe
- wr_vaddr  out  VA_SZ-12  latched miss_vaddr
- wr_asid  out  16  latched miss_asid
- wr_paddr  out  NPHYS-12  leaf PPN
- wr_gaux  out  4  {G,U,X,A}
- wr_2mB, wr_4mB, wr_1gB, wr_512gB  out  1 each  page size; wr_4mB is always 0
- done  out  1  one-cycle completion pulse
- fault_page  out  1  page fault, valid with done
- fault_access  out  1  access fault, valid with done

Behaviour:
- Reset (reset=0, async): state IDLE; miss_ready=1; all other outputs 0; the level counter and latches are cleared.
- States:
  - IDLE: accepts a miss. Latches vaddr/asid. Sets lvl = satp_mode ? 3 : 2 and ppn = satp_ppn. Next state REQ.
  - REQ: mem_req=1 with mem_addr = {ppn, vpn[lvl], 3'b000}, where vpn[l] = vaddr[12+9l+8 : 12+9l]. Moves to WAIT on mem_ack.
  - WAIT: waits for mem_rvalid, then decodes the PTE in the same cycle:
    - mem_rerr -> FAULT(access).
    - V=0, or (R=0 && W=1), or pte[63:54]!=0 -> FAULT(page).
    - R|X=0 (pointer): if lvl=0 -> FAULT(page); else ppn = pte[NPHYS-3:10], lvl--, go to REQ.
    - Leaf:
      - X=0 or A=0 -> FAULT(page). A is not updated by hardware.
      - Superpage with nonzero low PPN bits (lvl*9 bits) -> FAULT(page).
      - Otherwise FILL.
  - FILL: wr_entry=1 and done=1 for one cycle.
    - wr_paddr = pte PPN.
    - wr_gaux = {G,U,X,A}.
    - wr_512gB = (lvl==3), wr_1gB = (lvl==2), wr_2mB = (lvl==1).
    - Then IDLE.
  - FAULT: done=1 with exactly one of fault_page/fault_access for one cycle, no wr_entry. Then IDLE.
- Sv39: vaddr bits [VA_SZ-1:39] must equal bit 38, else an immediate FAULT(page) without any memory read. Sv48 performs no sign check at VA_SZ=48.
- flush:
  - In REQ before mem_ack: drop mem_req and go to IDLE.
  - In WAIT: go to DRAIN. DRAIN absorbs the outstanding mem_rvalid and then goes to IDLE with no done.
  - In FILL/FAULT the flush wins: no wr_entry, no done, go to IDLE.
  - flush in IDLE is ignored, and the same-cycle miss is still accepted.
- miss_ready=1 only in IDLE.
- wr_* outputs stay stable outside FILL. Only wr_entry qualifies them.
- Latency: 4KB Sv39 hit-free walk = 1 + 3 × (mem latency + 1) + 1 cycles.

Decomposition:
- Shared package holds:
  - PTE bit positions (V,R,W,X,U,G,A,D = 0..7; PPN starts at bit 10).
  - State enum {IDLE,REQ,WAIT,DRAIN,FILL,FAULT}.
  - Level constants.
- One sub-module, itlb_pte_check: combinational PTE decode giving leaf/pointer/page_fault and superpage alignment from (pte, lvl).

Test Plan:
- Sv39 4KB walk: satp_ppn=0x80000, vaddr=0x40203000, PTEs 0x20000401 / 0x20000801 / 0x048D144B.
  - Required: reads at 0x80000008, 0x80001008, 0x80002018.
  - Then wr_entry with wr_paddr=0x12345, all size bits 0, wr_gaux=4'b0011.
- 2MB leaf at level 1: PTE ppn=0x80200 with flags 0x4B -> wr_2mB=1, wr_paddr=0x80200. A second run with ppn=0x80201 -> done with fault_page=1 and no wr_entry.
- First PTE = 0 (V=0) -> exactly one memory read, then done with fault_page=1.
- mem_rerr=1 on the second read -> done with fault_access=1, miss_ready back to 1 the next cycle.
- flush asserted in WAIT of the second read -> the response is absorbed with no done and no wr_entry. A new miss is accepted afterwards and completes normally.
- reset deasserted then asserted low mid-WAIT -> mem_req=0 and miss_ready=1 immediately, without waiting for a clock edge.
